// File: rtl/ula_branch_stage_pkg.sv
// Shared definitions for the ULA branch stage: branch codes, flag indices and the buffered payload.
package ula_branch_stage_pkg;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam int unsigned FLAG_EQ   = 0;
  localparam int unsigned FLAG_MSB  = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_ZERO = 3;

  // Payload holds results up to MAX_XLEN bits; narrower stages zero-extend into it.
  localparam int unsigned MAX_XLEN = 64;

  typedef struct packed {
    logic [MAX_XLEN-1:0] result;
    logic [4:0]          rd;
    logic                reg_write;
  } payload_t;

endpackage

// File: rtl/ula_branch_stage_branch_cond.sv
// Combinational branch condition decode from ULA flags and funct3.
module branch_cond
  import ula_branch_stage_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] funct3,
  output logic       taken,
  output logic       illegal
);

  logic unused_zero_flag;
  assign unused_zero_flag = flags[FLAG_ZERO];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = flags[FLAG_EQ];
      F3_BNE:  taken = ~flags[FLAG_EQ];
      F3_BLT:  taken = flags[FLAG_MSB] ^ flags[FLAG_OVF];
      F3_BGE:  taken = ~(flags[FLAG_MSB] ^ flags[FLAG_OVF]);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ula_branch_stage.sv
// EX->MEM stage: 2-entry FIFO (head + skid) with branch resolution and one-cycle redirect pulse.
module ula_branch_stage
  import ula_branch_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [3:0]      in_flags,
  input  logic            in_is_branch,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            br_illegal
);

  payload_t        head_q, head_d, tail_q, tail_d, in_payload;
  logic [1:0]      count_q, count_d;
  logic            in_ready_q;
  logic            redirect_q, redirect_d;
  logic            br_illegal_q, br_illegal_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            cond_taken, cond_illegal;
  logic            push, pop;

  branch_cond u_branch_cond (
    .flags   (in_flags),
    .funct3  (in_funct3),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  always_comb begin
    in_payload.result    = MAX_XLEN'(in_result);
    in_payload.rd        = in_rd;
    in_payload.reg_write = in_reg_write & ~in_is_branch;

    // A flushed handshake never enters the FIFO nor raises a pulse.
    push = in_valid & in_ready_q & ~flush;
    pop  = (count_q != 2'd0) & out_ready;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = in_payload;
          else                 tail_d = in_payload;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = in_payload;
          end else begin
            head_d = tail_q;
            tail_d = in_payload;
          end
        end
        default: ;
      endcase
    end

    redirect_d    = push & in_is_branch & cond_taken;
    br_illegal_d  = push & in_is_branch & cond_illegal;
    redirect_pc_d = redirect_d ? (in_pc + in_imm) : redirect_pc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= 2'd0;
      in_ready_q    <= 1'b1;
      redirect_q    <= 1'b0;
      br_illegal_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      in_ready_q    <= (count_d != 2'd2);
      redirect_q    <= redirect_d;
      br_illegal_q  <= br_illegal_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (count_q != 2'd0);
  assign out_result    = head_q.result[XLEN-1:0];
  assign out_rd        = head_q.rd;
  assign out_reg_write = head_q.reg_write;
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign br_illegal    = br_illegal_q;

endmodule

// File: tb/tb_ula_branch_stage.sv
// Scoreboard bench for ula_branch_stage: directed vectors push expectations, a negedge monitor checks.
module tb_ula_branch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_result, in_pc, in_imm;
  logic [3:0]  in_flags;
  logic        in_is_branch;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        br_illegal;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] rq[$];
  int          ill_pending = 0;
  int          n_vec = 0;
  int          n_err = 0;

  ula_branch_stage #(.XLEN(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_flags      (in_flags),
    .in_is_branch  (in_is_branch),
    .in_funct3     (in_funct3),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .br_illegal    (br_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one instruction, holding it until in_ready, and records what must come out.
  task automatic send(input logic [63:0] res, input logic [4:0] rd, input logic rw,
                      input logic br, input logic [2:0] f3, input logic [3:0] fl,
                      input logic [63:0] pc, input logic [63:0] imm, input logic exp_rw,
                      input logic exp_taken, input logic [63:0] exp_pc,
                      input logic exp_ill, input logic do_flush);
    exp_t e;
    int   waited = 0;
    in_valid = 1'b1; in_result = res; in_rd = rd; in_reg_write = rw; in_is_branch = br;
    in_funct3 = f3; in_flags = fl; in_pc = pc; in_imm = imm; flush = do_flush;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      flush    = 1'b0;
      return;
    end
    if (!do_flush) begin
      e.res = res; e.rd = rd; e.rw = exp_rw;
      sb.push_back(e);
      if (exp_taken) rq.push_back(exp_pc);
      if (exp_ill) ill_pending++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    if (do_flush) sb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("out_valid_unexpected", 64'(sb.size()), 64'd1);
        end else begin
          check("out_result", out_result, sb[0].res);
          check("out_rd", 64'(out_rd), 64'(sb[0].rd));
          check("out_reg_write", 64'(out_reg_write), 64'(sb[0].rw));
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (redirect) begin
        if (rq.size() == 0) begin
          check("redirect_unexpected", 64'(rq.size()), 64'd1);
        end else begin
          check("redirect_pc", redirect_pc, rq[0]);
          void'(rq.pop_front());
        end
      end
      if (br_illegal) begin
        check("br_illegal_expected", 64'(ill_pending > 0), 64'd1);
        if (ill_pending > 0) ill_pending--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_is_branch = 1'b0;
    in_funct3 = '0; in_pc = '0; in_imm = '0; in_rd = '0; in_reg_write = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_redirect", 64'(redirect), 64'd0);
    check("rst_br_illegal", 64'(br_illegal), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_reg_write", 64'(out_reg_write), 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // Plain ALU result, one-cycle latency.
    send(64'h2A, 5'd5, 1'b1, 1'b0, 3'b000, 4'b0000, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_result", out_result, 64'h2A);
    idle(1);

    // BLT taken: 0x100 + 0x40.
    send(64'h11, 5'd3, 1'b1, 1'b1, 3'b100, 4'b0010, 64'h100, 64'h40, 1'b0, 1'b1, 64'h140, 1'b0,
         1'b0);
    check("blt_redirect", 64'(redirect), 64'd1);
    check("blt_redirect_pc", redirect_pc, 64'h140);
    idle(1);
    check("blt_redirect_pulse_end", 64'(redirect), 64'd0);

    // BGE taken (MSB^OVF=0) and not taken (MSB^OVF=1).
    send(64'h22, 5'd4, 1'b1, 1'b1, 3'b101, 4'b0110, 64'h200, 64'h10, 1'b0, 1'b1, 64'h210, 1'b0,
         1'b0);
    check("bge_taken", 64'(redirect), 64'd1);
    send(64'h23, 5'd4, 1'b0, 1'b1, 3'b101, 4'b0100, 64'h300, 64'h10, 1'b0, 1'b0, 64'h0, 1'b0,
         1'b0);
    check("bge_not_taken", 64'(redirect), 64'd0);

    // BEQ/BNE both ways, BNE with negative offset, and PC wrap-around.
    send(64'h30, 5'd1, 1'b1, 1'b1, 3'b000, 4'b0001, 64'h400, 64'h8, 1'b0, 1'b1, 64'h408, 1'b0,
         1'b0);
    send(64'h31, 5'd1, 1'b1, 1'b1, 3'b000, 4'b0000, 64'h400, 64'h8, 1'b0, 1'b0, 64'h0, 1'b0,
         1'b0);
    send(64'h32, 5'd2, 1'b1, 1'b1, 3'b001, 4'b0000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1,
         64'hFF8, 1'b0, 1'b0);
    send(64'h33, 5'd2, 1'b1, 1'b1, 3'b001, 4'b1001, 64'h1000, 64'h8, 1'b0, 1'b0, 64'h0, 1'b0,
         1'b0);
    send(64'h34, 5'd6, 1'b0, 1'b1, 3'b100, 4'b0100, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b0, 1'b1,
         64'h10, 1'b0, 1'b0);

    // Unsupported funct3: illegal pulse, no redirect.
    send(64'h40, 5'd7, 1'b1, 1'b1, 3'b110, 4'b0001, 64'h500, 64'h4, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    check("illegal_pulse", 64'(br_illegal), 64'd1);
    check("illegal_no_redirect", 64'(redirect), 64'd0);
    idle(1);
    check("illegal_pulse_end", 64'(br_illegal), 64'd0);

    // Non-branch whose flags/funct3 look like a taken BEQ keeps reg_write and never redirects.
    send(64'h50, 5'd8, 1'b1, 1'b0, 3'b000, 4'b0001, 64'h600, 64'h4, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    idle(2);

    // Backpressure: two fill the FIFO, third waits until downstream drains.
    out_ready = 1'b0;
    send(64'hA1, 5'd10, 1'b1, 1'b0, 3'b000, 4'b0000, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    send(64'hA2, 5'd11, 1'b1, 1'b0, 3'b000, 4'b0000, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    fork
      send(64'hA3, 5'd12, 1'b1, 1'b0, 3'b000, 4'b0000, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0,
           1'b0);
      begin
        idle(2);
        check("full_hold_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    idle(4);
    check("drain_order_done", 64'(sb.size()), 64'd0);

    // Flush coincident with an accepted taken BEQ: nothing enters, no redirect.
    send(64'hB0, 5'd13, 1'b1, 1'b1, 3'b000, 4'b0001, 64'h700, 64'h20, 1'b0, 1'b1, 64'h720, 1'b0,
         1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_no_redirect", 64'(redirect), 64'd0);
    idle(1);

    // Flush on the cycle a redirect is already high keeps that pulse.
    out_ready = 1'b0;
    send(64'hC0, 5'd14, 1'b1, 1'b1, 3'b001, 4'b0000, 64'h800, 64'h10, 1'b0, 1'b1, 64'h810, 1'b0,
         1'b0);
    flush = 1'b1;
    #1;
    check("flush_keeps_redirect", 64'(redirect), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    check("flush_clears_fifo", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    idle(1);

    // Asynchronous reset mid-transfer drops entries and pending pulses at once.
    out_ready = 1'b0;
    send(64'hD0, 5'd15, 1'b1, 1'b1, 3'b000, 4'b0001, 64'h900, 64'h4, 1'b0, 1'b1, 64'h904, 1'b0,
         1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_redirect", 64'(redirect), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    rq.delete();
    ill_pending = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    send(64'hE0, 5'd16, 1'b1, 1'b0, 3'b000, 4'b0000, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    idle(3);
    check("end_sb_empty", 64'(sb.size()), 64'd0);
    check("end_redirects_seen", 64'(rq.size()), 64'd0);
    check("end_illegal_seen", 64'(ill_pending), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ula_branch_stage.md
ULA_BRANCH_STAGE -- requirements
Module: ula_branch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of result, pc, imm.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream EX holds a valid ULA result.
REQ-005 SHALL have port in_ready  output  1  stage can accept; registered output.
REQ-006 SHALL have port in_result  input  XLEN  ULA result.
REQ-007 SHALL have port in_flags  input  4  ULA flags: [0] equal, [1] result MSB, [2] overflow, [3] zero-tied.
REQ-008 SHALL have port in_is_branch  input  1  instruction is a conditional branch.
REQ-009 SHALL have port in_funct3  input  3  branch kind: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, others unsupported.
REQ-010 SHALL have ports in_pc, in_imm  input  XLEN each  branch PC and sign-extended offset.
REQ-011 SHALL have ports in_rd  input  5 and in_reg_write  input  1  writeback destination and enable.
REQ-012 SHALL have port flush  input  1  discards all buffered entries.
REQ-013 SHALL have ports out_valid  output  1 and out_ready  input  1  downstream (MEM) handshake.
REQ-014 SHALL have ports out_result  output  XLEN, out_rd  output  5, out_reg_write  output  1.
REQ-015 SHALL have ports redirect  output  1, redirect_pc  output  XLEN  taken-branch fetch redirect.
REQ-016 SHALL have port br_illegal  output  1  one-cycle pulse on unsupported funct3.

Function
REQ-017 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output); all outputs registered.
REQ-018 Storage is a 2-entry FIFO (main + skid); in_ready = occupancy<2 computed from registered count.
REQ-019 Latency: accepted entry appears on out_* the next cycle when FIFO was empty.
REQ-020 Simultaneous accept and drain at occupancy 1 or 2 keeps occupancy unchanged; FIFO order preserved.
REQ-021 Taken condition at acceptance: BEQ flags[0]; BNE !flags[0]; BLT flags[1]^flags[2]; BGE !(flags[1]^flags[2]).
REQ-022 Unsupported funct3 with in_is_branch: not taken, br_illegal pulses 1 cycle after acceptance.
REQ-023 On accepted taken branch: redirect=1 for exactly one cycle next cycle, redirect_pc=in_pc+in_imm mod 2^XLEN.
REQ-024 Branches are enqueued with out_reg_write forced 0; out_result carries ULA result unchanged.
REQ-025 flush clears occupancy to 0 next edge; a same-cycle input handshake is discarded (flush wins) and generates no redirect/br_illegal.
REQ-026 flush does not cancel a redirect pulse already asserted that cycle.
REQ-027 out_* payload holds stable while out_valid&!out_ready.
REQ-028 in_valid while in_ready=0 has no effect; upstream holds data.

Reset
REQ-029 On reset: occupancy 0, out_valid 0, in_ready 1, redirect 0, br_illegal 0, out_result 0, out_rd 0, out_reg_write 0, redirect_pc 0.
REQ-030 Reset mid-transfer discards all entries and pending pulses immediately (asynchronous).

Structure
REQ-031 Shared package SHALL hold funct3 branch codes, flag bit indices (BEQ=0, MSB=1, Overflow=2), and the payload record (result, rd, reg_write).
REQ-032 Branch condition decode SHALL be a sub-module branch_cond (combinational, flags+funct3 -> taken, illegal).

Verification
REQ-033 After reset, in_valid=1 result=0x2A rd=5 reg_write=1 -> next cycle out_valid=1 out_result=0x2A out_rd=5.
REQ-034 BLT with flags=4'b0010, pc=0x100, imm=0x40 -> redirect pulse 1 cycle, redirect_pc=0x140, out_reg_write=0.
REQ-035 BGE with flags=4'b0110 (MSB^OVF=0) -> redirect=1; same with flags=4'b0100 -> redirect=0.
REQ-036 out_ready=0, push 3 entries -> in_ready=0 after 2; release out_ready -> entries exit in order, none lost.
REQ-037 flush coincident with accepted taken BEQ (flags=4'b0001) -> no redirect, out_valid=0 next cycle.
REQ-038 funct3=3'b110 branch -> br_illegal 1-cycle pulse, redirect=0.
